// File: rtl/way_sel_mux_pipe.sv
// way_sel_mux_pipe
//   N-way cache line read mux for the set-associative read path. The
//   tag-compare hit vector selects one way's line. A 2-entry buffer
//   (output register plus skid register) sits behind it, with valid/ready
//   handshakes on both sides. Each beat carries a hit flag, the encoded way
//   index and a select-encoding error flag. When more than one select bit is
//   set, the lowest set index wins. A sticky flag records any multi-hit beat
//   accepted since the last clear.
//
// Ports
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_valid, o_ready  upstream handshake (o_ready comes straight from a flop)
//   i_data            NUM_WAYS lines, way w at [w*LINE_SIZE_BITS +: LINE_SIZE_BITS]
//   i_sel             way-hit vector (expected one-hot)
//   o_valid, i_ready  downstream handshake
//   o_data            selected line (zero on a miss)
//   o_hit             beat had at least one select bit set
//   o_way             encoded selected way
//   o_sel_err         beat had more than one select bit set
//   i_err_clr         clear the sticky error
//   o_err_sticky      a multi-hit beat was accepted since the last clear
module way_sel_mux_pipe #(
  parameter int LINE_SIZE_BITS = 512,
  parameter int NUM_WAYS       = 4,
  parameter int WAY_IDX_BITS   = $clog2(NUM_WAYS)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [NUM_WAYS*LINE_SIZE_BITS-1:0] i_data,
  input  logic [NUM_WAYS-1:0]                i_sel,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [LINE_SIZE_BITS-1:0]          o_data,
  output logic                               o_hit,
  output logic [WAY_IDX_BITS-1:0]            o_way,
  output logic                               o_sel_err,
  input  logic                               i_err_clr,
  output logic                               o_err_sticky
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } occ_t;

  // Lowest set select bit wins. The scan runs from the top down, so the last
  // assignment made is the lowest index.
  function automatic logic [WAY_IDX_BITS-1:0] first_way(input logic [NUM_WAYS-1:0] sel);
    first_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (sel[w]) first_way = WAY_IDX_BITS'(w);
    end
  endfunction

  function automatic logic [LINE_SIZE_BITS-1:0] pick_line(
    input logic [NUM_WAYS*LINE_SIZE_BITS-1:0] lines,
    input logic [NUM_WAYS-1:0]                sel
  );
    pick_line = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (sel[w]) pick_line = lines[w*LINE_SIZE_BITS +: LINE_SIZE_BITS];
    end
  endfunction

  // Clearing the lowest set bit leaves something behind only if two or more
  // bits were set.
  function automatic logic multi_hit(input logic [NUM_WAYS-1:0] sel);
    multi_hit = (sel & (sel - NUM_WAYS'(1))) != '0;
  endfunction

  occ_t                      state_q;
  occ_t                      state_nxt;
  logic                      ready_q;
  logic                      accept;
  logic                      take;
  logic                      vld_p1;
  logic                      load_out_new;
  logic                      load_out_skid;
  logic                      load_skid;

  logic [LINE_SIZE_BITS-1:0] data_p0;
  logic                      hit_p0;
  logic [WAY_IDX_BITS-1:0]   way_p0;
  logic                      err_p0;

  logic [LINE_SIZE_BITS-1:0] data_p1;
  logic                      hit_p1;
  logic [WAY_IDX_BITS-1:0]   way_p1;
  logic                      err_p1;

  logic [LINE_SIZE_BITS-1:0] data_sk;
  logic                      hit_sk;
  logic [WAY_IDX_BITS-1:0]   way_sk;
  logic                      err_sk;

  logic                      err_sticky_q;

  // ---- Stage p0: select decode on the incoming beat ----
  assign data_p0 = pick_line(i_data, i_sel);
  assign hit_p0  = |i_sel;
  assign way_p0  = first_way(i_sel);
  assign err_p0  = multi_hit(i_sel);

  // While in FULL2, ready_q is low, so i_valid is ignored.
  assign accept = i_valid & ready_q;
  assign take   = vld_p1 & i_ready;

  // Occupancy state register. The ready flop follows the next state, so
  // o_ready never depends combinationally on i_valid or i_ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ready_q <= (state_nxt != FULL2);
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_nxt = FULL1;
      end
      FULL1: begin
        if (accept && !take)      state_nxt = FULL2;
        else if (!accept && take) state_nxt = EMPTY;
      end
      FULL2: begin
        if (take) state_nxt = FULL1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    vld_p1        = 1'b0;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      EMPTY: begin
        load_out_new = accept;
      end
      FULL1: begin
        vld_p1       = 1'b1;
        load_out_new = accept & take;
        load_skid    = accept & ~take;
      end
      FULL2: begin
        vld_p1        = 1'b1;
        load_out_skid = take;
      end
      default: begin
        vld_p1 = 1'b0;
      end
    endcase
  end

  // ---- Stage p1: output register, refilled from p0 or from the skid ----
  // The data path has no reset. Outputs are masked by vld_p1 instead, so
  // they read zero whenever the block is empty.
  always_ff @(posedge i_clk) begin
    if (load_out_new) begin
      data_p1 <= data_p0;
      hit_p1  <= hit_p0;
      way_p1  <= way_p0;
      err_p1  <= err_p0;
    end else if (load_out_skid) begin
      data_p1 <= data_sk;
      hit_p1  <= hit_sk;
      way_p1  <= way_sk;
      err_p1  <= err_sk;
    end
  end

  // ---- Skid register: catches a beat accepted while p1 is stalled ----
  always_ff @(posedge i_clk) begin
    if (load_skid) begin
      data_sk <= data_p0;
      hit_sk  <= hit_p0;
      way_sk  <= way_p0;
      err_sk  <= err_p0;
    end
  end

  // If a set and a clear arrive in the same cycle, the set wins.
  always_ff @(posedge i_clk) begin
    if (i_rst)                 err_sticky_q <= 1'b0;
    else if (accept && err_p0) err_sticky_q <= 1'b1;
    else if (i_err_clr)        err_sticky_q <= 1'b0;
  end

  assign o_ready      = ready_q;
  assign o_valid      = vld_p1;
  assign o_data       = vld_p1 ? data_p1 : '0;
  assign o_hit        = vld_p1 & hit_p1;
  assign o_way        = vld_p1 ? way_p1 : '0;
  assign o_sel_err    = vld_p1 & err_p1;
  assign o_err_sticky = err_sticky_q;

endmodule
